// File: rtl/rotor_step_ctrl_if.sv
// Handshake, configuration and datapath signals of the rotor stepping controller.
// The controller uses the slave view; the producer/consumer/datapath side uses master.
interface rotor_step_ctrl_if;
  logic       load;
  logic [5:0] load_r0;
  logic [5:0] load_r1;
  logic [5:0] load_r2;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_char;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_char;
  logic [5:0] dp_in;
  logic [5:0] dp_r0_pos;
  logic [5:0] dp_r1_pos;
  logic [5:0] dp_r2_pos;
  logic [5:0] dp_out;
  logic       busy;

  modport slave (
    input  load, load_r0, load_r1, load_r2, in_valid, in_char, out_ready, dp_out,
    output in_ready, out_valid, out_char, dp_in, dp_r0_pos, dp_r1_pos, dp_r2_pos, busy
  );

  modport master (
    output load, load_r0, load_r1, load_r2, in_valid, in_char, out_ready, dp_out,
    input  in_ready, out_valid, out_char, dp_in, dp_r0_pos, dp_r1_pos, dp_r2_pos, busy
  );
endinterface

// File: rtl/rotor_step_ctrl.sv
// Three-rotor stepping sequencer: accepts a character, steps rotors with the
// odometer/double-step rule, waits for the datapath to settle, returns its result.
module rotor_step_ctrl #(
  parameter int ALPHABET = 26,
  parameter int NOTCH0   = 21,
  parameter int NOTCH1   = 4,
  parameter int DP_LAT   = 1
) (
  input logic              clk,
  input logic              rst_n,
  rotor_step_ctrl_if.slave bus
);

  localparam int              CW       = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [6:0]      ALPHA    = 7'(ALPHABET);
  localparam logic [5:0]      LAST     = 6'(ALPHABET - 1);
  localparam logic [5:0]      N0       = 6'(NOTCH0);
  localparam logic [5:0]      N1       = 6'(NOTCH1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(DP_LAT - 1);

  typedef enum logic [1:0] {IDLE, STEP, WAIT, OUT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [5:0]    r0, r1, r2;
  logic [5:0]    dp_in_q, out_char_q;

  function automatic logic [5:0] wrap_inc(input logic [5:0] p);
    return (p == LAST) ? '0 : p + 6'd1;
  endfunction

  function automatic logic [5:0] clamp(input logic [5:0] v);
    return ({1'b0, v} >= ALPHA) ? '0 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        bus.in_ready = !bus.load;
        if (!bus.load && bus.in_valid) state_nx = STEP;
      end
      STEP: state_nx = WAIT;
      WAIT: if (cnt == '0) state_nx = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0         <= '0;
      r1         <= '0;
      r2         <= '0;
      dp_in_q    <= '0;
      out_char_q <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            r0 <= clamp(bus.load_r0);
            r1 <= clamp(bus.load_r1);
            r2 <= clamp(bus.load_r2);
          end else if (bus.in_valid) begin
            dp_in_q <= bus.in_char;
          end
        end
        STEP: begin
          // All three decisions use pre-step positions; r1 at its own notch
          // advances again (double step) and carries into r2.
          r0 <= wrap_inc(r0);
          if (r0 == N0 || r1 == N1) r1 <= wrap_inc(r1);
          if (r1 == N1)             r2 <= wrap_inc(r2);
          cnt <= CNT_INIT;
        end
        WAIT: begin
          if (cnt == '0) out_char_q <= bus.dp_out;
          else           cnt        <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.dp_in     = dp_in_q;
  assign bus.dp_r0_pos = r0;
  assign bus.dp_r1_pos = r1;
  assign bus.dp_r2_pos = r2;
  assign bus.out_char  = out_char_q;

endmodule

// File: doc/rotor_step_ctrl.md
# rotor_step_ctrl

Sequencing controller for the combinational three-rotor forward/back datapath. Accepts one plaintext character at a time over a valid/ready handshake and steps the rotor positions by Enigma odometer rules, including the middle-rotor double step. It drives the new positions and the character into the datapath, waits a fixed settle time, then returns the datapath result over a second valid/ready handshake. Rotor start positions are loaded through a configuration strobe while the controller is idle.

## Interface
- ALPHABET, 26: symbol count; positions wrap modulo ALPHABET (2..64)
- NOTCH0, 21: fast-rotor (r0) turnover position (V)
- NOTCH1, 4: middle-rotor (r1) turnover position (E)
- DP_LAT, 1: datapath settle cycles before capture (≥1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  load start positions (honoured only in IDLE)
- load_r0, load_r1, load_r2  in  6 each  start positions
- in_valid  in  1  input character valid
- in_ready  out  1  controller can accept a character
- in_char  in  6  input character
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_char  out  6  encrypted character
- dp_in  out  6  character to datapath (registered)
- dp_r0_pos, dp_r1_pos, dp_r2_pos  out  6 each  rotor positions to datapath (registered)
- dp_out  in  6  datapath result (combinational from dp_* outputs)
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, STEP, WAIT, OUT.
- IDLE: in_ready=1 unless load=1. If load=1, positions take load_rN; any value ≥ALPHABET is stored as 0. load has priority over in_valid; no character is accepted in that cycle. Otherwise, on in_valid&&in_ready, latch in_char into dp_in and go to STEP.
- STEP (1 cycle): update all positions at once, using pre-step values:
  - r0 ← r0+1.
  - r1 ← r1+1 if r0==NOTCH0 or r1==NOTCH1 (the second term is the double step).
  - r2 ← r2+1 if r1==NOTCH1.
  - Every increment wraps ALPHABET-1 → 0.
  - Go to WAIT and load the settle counter with DP_LAT-1.
- WAIT: count down. In the cycle where the counter is 0, capture dp_out into out_char and go to OUT.
- OUT: out_valid=1. out_char, dp_in and positions are held stable until out_valid&&out_ready, then go to IDLE.
- The stepping logic gives the result for the character's own stepped positions. There is no stepping on load and no stepping without a character.
- in_char ≥ALPHABET is passed through unchanged; the controller never checks it.
- load, in_valid and out_ready are ignored outside their states. A load in STEP, WAIT or OUT is dropped, not queued.

## Timing
- Reset: state IDLE; all positions 0; dp_in=0, out_char=0; out_valid=0, busy=0; in_ready=1 after release.
- An asynchronous rst_n assertion at any point, including mid-WAIT or OUT, aborts the character immediately with no output. Positions return to 0.
- Latency, with accept at edge T: positions update at T+1. dp_out is captured at edge T+1+DP_LAT. out_valid rises after that edge, i.e. it is high in cycle T+1+DP_LAT, which is 2+DP_LAT cycles after the accept cycle.
- Throughput: at most one character per 3+DP_LAT cycles with out_ready held high. in_ready is low from the accept edge until the cycle after the out handshake.
- Loaded positions appear on dp_rN_pos the cycle after the load edge.

## Test plan
- Reset, then load 0/0/0 and send char 0 with out_ready=1 → positions (r2,r1,r0)=(0,0,1); out_valid high exactly 3 cycles after the accept cycle (DP_LAT=1); out_char equals dp_out from the bench model.
- Double step: load r0=20, r1=3, r2=0; send 3 chars.
  - After char 1: (0,3,21).
  - After char 2: (0,4,22).
  - After char 3: (1,5,23).
- Wrap: load r0=25, r1=25, r2=25, with NOTCH0=25 and NOTCH1=25 overridden → after one char: (0,0,0).
- Backpressure: hold out_ready=0 for 5 cycles in OUT.
  - out_valid stays 1; out_char and positions stay constant; in_ready stays 0.
  - in_valid and load pulses in that window are ignored.
- Priority and range: assert load and in_valid together in IDLE → load taken, char not accepted. load_r1=40 → r1 stored as 0.
- Drop rst_n during WAIT → out_valid=0 with no transaction, positions 0. After release, the next char behaves as in the first scenario.
